// File: rtl/stream_demux_1to2.sv
// ---------------------------------------------------------------------------
// stream_demux_1to2
//
// Registered 1-to-2 stream demultiplexer. Each accepted input word is routed
// by its in_sel bit into one of two independent 2-entry output FIFOs. Each
// output has its own valid/ready handshake, and word order is preserved per
// output.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready handshake for the producer
//   in_data, in_sel   offered word and its destination (0 -> out0, 1 -> out1)
//   out0_valid/out0_ready/out0_data  head of destination-0 buffer
//   out1_valid/out1_ready/out1_data  head of destination-1 buffer
//   cnt0, cnt1        words routed to out0/out1, wrapping at 16 bits
//                     (present only when STREAM_DEMUX_STATS_EN is defined)
//
// Optional feature macro: STREAM_DEMUX_STATS_EN
// ---------------------------------------------------------------------------
module stream_demux_1to2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sel,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [DATA_WIDTH-1:0] out1_data
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [15:0]           cnt0,
  output logic [15:0]           cnt1
`endif
);

  // Occupancy of one output buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  occ_q  [2];
  occ_e                  occ_d  [2];
  logic [DATA_WIDTH-1:0] head_q [2];
  logic [DATA_WIDTH-1:0] head_d [2];
  logic [DATA_WIDTH-1:0] tail_q [2];
  logic [DATA_WIDTH-1:0] tail_d [2];

  logic [1:0] full_s;
  logic [1:0] valid_s;
  logic [1:0] oready_s;
  logic [1:0] push_s;
  logic [1:0] pop_s;

  // Occupancy flags and consumer readiness gathered into vectors.
  always_comb begin
    full_s   = 2'b00;
    valid_s  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      full_s[i]  = (occ_q[i] == OCC_TWO);
      valid_s[i] = (occ_q[i] != OCC_EMPTY);
    end
    oready_s = {out1_ready, out0_ready};
  end

  // Producer handshake. in_ready looks only at the selected buffer's own
  // occupancy, never at the consumer ready, so a full buffer refuses a push
  // even in the cycle it is being popped.
  always_comb begin
    in_ready  = in_sel ? !full_s[1] : !full_s[0];
    push_s    = 2'b00;
    push_s[0] = in_valid && in_ready && !in_sel;
    push_s[1] = in_valid && in_ready && in_sel;
  end

  // Consumer handshake.
  always_comb begin
    pop_s = valid_s & oready_s;
  end

  // FSM state register: buffer occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q[0] <= OCC_EMPTY;
      occ_q[1] <= OCC_EMPTY;
    end else begin
      occ_q[0] <= occ_d[0];
      occ_q[1] <= occ_d[1];
    end
  end

  // FSM next-state logic, one independent machine per destination.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      occ_d[i] = occ_q[i];
      case (occ_q[i])
        OCC_EMPTY: begin
          if (push_s[i]) begin
            occ_d[i] = OCC_ONE;
          end else begin
            occ_d[i] = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (push_s[i] && !pop_s[i]) begin
            occ_d[i] = OCC_TWO;
          end else if (!push_s[i] && pop_s[i]) begin
            occ_d[i] = OCC_EMPTY;
          end else begin
            occ_d[i] = OCC_ONE;
          end
        end
        OCC_TWO: begin
          // A push cannot happen here because in_ready is low for this side.
          if (pop_s[i]) begin
            occ_d[i] = OCC_ONE;
          end else begin
            occ_d[i] = OCC_TWO;
          end
        end
        default: begin
          occ_d[i] = OCC_EMPTY;
        end
      endcase
    end
  end

  // FSM output logic: valid straight from occupancy, data from the head
  // register so there is no combinational path from in_data.
  always_comb begin
    out0_valid = valid_s[0];
    out1_valid = valid_s[1];
    out0_data  = head_q[0];
    out1_data  = head_q[1];
  end

  // Buffer storage next values. The head always holds the oldest word; the
  // tail only holds the second word while the buffer is in TWO.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      head_d[i] = head_q[i];
      tail_d[i] = tail_q[i];
      case (occ_q[i])
        OCC_EMPTY: begin
          if (push_s[i]) begin
            head_d[i] = in_data;
          end else begin
            head_d[i] = head_q[i];
          end
        end
        OCC_ONE: begin
          if (push_s[i] && pop_s[i]) begin
            // Old head leaves, new word takes its place directly.
            head_d[i] = in_data;
          end else if (push_s[i]) begin
            tail_d[i] = in_data;
          end else begin
            head_d[i] = head_q[i];
          end
        end
        OCC_TWO: begin
          if (pop_s[i]) begin
            head_d[i] = tail_q[i];
          end else begin
            head_d[i] = head_q[i];
          end
        end
        default: begin
          head_d[i] = head_q[i];
          tail_d[i] = tail_q[i];
        end
      endcase
    end
  end

  // Buffer storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
      end
    end
  end

`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];

  // Per-destination push counters, wrapping naturally at 16 bits.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i] + {15'd0, push_s[i]};
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q[0] <= 16'd0;
      cnt_q[1] <= 16'd0;
    end else begin
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Counter outputs.
  always_comb begin
    cnt0 = cnt_q[0];
    cnt1 = cnt_q[1];
  end
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Self-checking bench for stream_demux_1to2: a queue-based model of the two
// output streams plus directed stimulus with hand-computed expectations.
module tb_stream_demux_1to2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  stream_demux_1to2 #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each destination is an ordered queue of at most two words.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [15:0] m_cnt0;
  logic [15:0] m_cnt1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m_cnt0 <= 16'd0;
      m_cnt1 <= 16'd0;
    end else begin
      // Acceptance is decided on the size before this edge's pop.
      if (in_valid && in_sel && q1.size() < 2) begin
        if (q1.size() != 0 && out1_ready) q1.pop_front();
        q1.push_back(in_data);
        m_cnt1 <= m_cnt1 + 16'd1;
      end else if (q1.size() != 0 && out1_ready) begin
        q1.pop_front();
      end
      if (in_valid && !in_sel && q0.size() < 2) begin
        if (q0.size() != 0 && out0_ready) q0.pop_front();
        q0.push_back(in_data);
        m_cnt0 <= m_cnt0 + 16'd1;
      end else if (q0.size() != 0 && out0_ready) begin
        q0.pop_front();
      end
    end
  end

  // Compare process: every falling edge, DUT against model.
  always @(negedge clk) begin
    chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
    chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
    chk("in_ready", {31'd0, in_ready},
        {31'd0, (in_sel ? (q1.size() < 2) : (q0.size() < 2))});
    if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
    if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
`ifdef STREAM_DEMUX_STATS_EN
    chk("cnt0", {16'd0, cnt0}, {16'd0, m_cnt0});
    chk("cnt1", {16'd0, cnt1}, {16'd0, m_cnt1});
`endif
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [31:0] d);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 32'd0;
    in_sel     = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (3) tick();
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    rst = 1'b0;
    tick();
    #1;
    // Idle after reset
    chk("idle_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("idle_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("idle_out0_data", out0_data, 32'd0);
    chk("idle_out1_data", out1_data, 32'd0);
    chk("idle_in_ready_sel0", {31'd0, in_ready}, 32'd1);
    in_sel = 1'b1;
    #1;
    chk("idle_in_ready_sel1", {31'd0, in_ready}, 32'd1);
    in_sel = 1'b0;

    // Single word, one-cycle latency
    out0_ready = 1'b1;
    drive(1'b1, 1'b0, 32'hA5A5_A5A5);
    tick();
    #1;
    chk("single_out0_valid", {31'd0, out0_valid}, 32'd1);
    chk("single_out0_data", out0_data, 32'hA5A5_A5A5);
    chk("single_out1_valid", {31'd0, out1_valid}, 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    tick();
    #1;
    chk("single_out0_drained", {31'd0, out0_valid}, 32'd0);

    // Stalled consumer: two accepted, third refused
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'h2);
    tick();
    drive(1'b1, 1'b0, 32'h3);
    #1;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    #1;
    chk("full_head", out0_data, 32'h1);
    out0_ready = 1'b1;
    tick();
    #1;
    chk("pop1_head", out0_data, 32'h2);
    chk("pop1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    #1;
    chk("pop2_head", out0_data, 32'h3);
    chk("pop2_valid", {31'd0, out0_valid}, 32'd1);
    drive(1'b0, 1'b0, 32'd0);
    tick();
    #1;
    chk("drain_valid", {31'd0, out0_valid}, 32'd0);

    // out1 stalled and full, alternating destinations
    out1_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h11);
    tick();
    drive(1'b1, 1'b1, 32'h22);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i[0], 32'h100 + i);
      #1;
      if (i[0]) chk("alt_sel1_refused", {31'd0, in_ready}, 32'd0);
      else      chk("alt_sel0_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    drive(1'b0, 1'b0, 32'd0);
    tick();
    #1;
    chk("alt_out1_head", out1_data, 32'h11);
    chk("alt_out1_valid", {31'd0, out1_valid}, 32'd1);

    // Both buffers in TWO, then asynchronous reset
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'h55);
    tick();
    drive(1'b1, 1'b0, 32'h66);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    #1;
    chk("two_out0_valid", {31'd0, out0_valid}, 32'd1);
    chk("two_out1_valid", {31'd0, out1_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("arst_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("arst_out0_data", out0_data, 32'd0);
    chk("arst_out1_data", out1_data, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 32'hBEEF);
    tick();
    #1;
    chk("post_rst_out1_data", out1_data, 32'hBEEF);
    chk("post_rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    tick();
    #1;
    chk("post_rst_out1_drained", {31'd0, out1_valid}, 32'd0);

`ifdef STREAM_DEMUX_STATS_EN
    // Counter wrap: 65537 pushes to out1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out1_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 1'b1, i);
      tick();
    end
    drive(1'b0, 1'b0, 32'd0);
    tick();
    #1;
    chk("wrap_cnt1", {16'd0, cnt1}, 32'd1);
    chk("wrap_cnt0", {16'd0, cnt0}, 32'd0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
